perf_counter_bank: RTL and testbench

Machine-mode performance counter bank for the RV32 core: hard-wired `mcycle` and `minstret` plus `NUM_HPM` programmable `mhpmcounter3+` counters with event selection, `mcountinhibit`, and split 32-bit low/high CSR access. It replaces the fixed `MCYCLE`/`MINSTRET` registers in the CSR file. It sits beside the CSR file, which forwards 12-bit CSR addresses to it:

- Reads are combinational, sampled in execute.
- Writes are committed from writeback.

---
 rtl/perf_counter_bank_pkg.sv | 35 +++
 rtl/perf_counter_bank_hpm_counter.sv | 45 ++++
 rtl/perf_counter_bank.sv | 169 ++++++++++++++++
 tb/tb_perf_counter_bank.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_counter_bank_pkg.sv
// Shared definitions for the machine-mode performance counter bank:
// CSR address constants, half-write selector and small helpers.
package perf_counter_bank_pkg;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
  localparam logic [11:0] CSR_MHPMOVF       = 12'h7C0;

  typedef enum logic [1:0] {
    HALF_NONE,
    HALF_LO,
    HALF_HI
  } counterWriteHalf_;

  // Counter slots are packed (cycle, instret, hpm3, hpm4, ...); index 1 has no slot.
  function automatic int unsigned slotToCsr(input int unsigned slot);
    return (slot == 0) ? 0 : slot + 1;
  endfunction

  function automatic logic [31:0] inhibitMask(input int unsigned numHpm);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int unsigned i = 0; i < numHpm; i++) begin
      m[5'(i + 3)] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/perf_counter_bank_hpm_counter.sv
// One counter slice: width-parameterised register with increment enable,
// 32-bit half writes (write wins over increment) and wrap detection.
module hpm_counter
  import perf_counter_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             incEn_i,
  input  counterWriteHalf_ writeHalf_i,
  input  logic [31:0]      writeData_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    wrap_o  = 1'b0;
    case (writeHalf_i)
      HALF_LO: count_d[31:0]       = writeData_i;
      HALF_HI: count_d[WIDTH-1:32] = writeData_i[WIDTH-33:0];
      default: begin
        if (incEn_i) begin
          count_d = count_q + WIDTH'(1);
          wrap_o  = &count_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Machine-mode performance counter bank: mcycle, minstret and NUM_HPM
// programmable counters. Optional overflow tracking via PERF_COUNTER_OVF_EN.
module perf_counter_bank
  import perf_counter_bank_pkg::*;
#(
  parameter int unsigned NUM_HPM       = 4,
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter int unsigned NUM_EVENTS    = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  instretEvent,
  input  logic [NUM_EVENTS-1:0] hpmEvents,
  input  logic [11:0]           csrReadAddress,
  output logic [31:0]           csrReadData,
  output logic                  csrReadHit,
  input  logic                  csrWriteEnable,
  input  logic [11:0]           csrWriteAddress,
  input  logic [31:0]           csrWriteData
`ifdef PERF_COUNTER_OVF_EN
  ,
  output logic                  perfIrq
`endif
);

  localparam int unsigned EVENT_SEL_WIDTH = $clog2(NUM_EVENTS + 1);
  localparam int unsigned NUM_CNT         = NUM_HPM + 2;
  localparam int unsigned SEL_SLOTS       = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [31:0] INHIBIT_MASK    = inhibitMask(NUM_HPM);

  logic [COUNTER_WIDTH-1:0]   count     [NUM_CNT];
  logic [63:0]                countExt  [NUM_CNT];
  counterWriteHalf_           writeHalf [NUM_CNT];
  logic [NUM_CNT-1:0]         incEn;
  logic [NUM_CNT-1:0]         wrap;

  logic [31:0]                inhibit_q, inhibit_d;
  logic [EVENT_SEL_WIDTH-1:0] sel_q [SEL_SLOTS];
  logic [EVENT_SEL_WIDTH-1:0] sel_d [SEL_SLOTS];

  // Bit 0 is the "count nothing" selector, so selector k indexes hpmEvents[k-1].
  logic [NUM_EVENTS:0]        eventVec;
  assign eventVec = {hpmEvents, 1'b0};

  for (genvar g = 0; g < NUM_CNT; g++) begin : gen_cnt
    hpm_counter #(
      .WIDTH (COUNTER_WIDTH)
    ) u_cnt (
      .clk         (clk),
      .resetN      (resetN),
      .incEn_i     (incEn[g]),
      .writeHalf_i (writeHalf[g]),
      .writeData_i (csrWriteData),
      .count_o     (count[g]),
      .wrap_o      (wrap[g])
    );
    assign countExt[g] = 64'(count[g]);
  end

  assign incEn[0] = ~inhibit_q[0];
  assign incEn[1] = instretEvent & ~inhibit_q[2];
  for (genvar g = 0; g < NUM_HPM; g++) begin : gen_hpm_inc
    assign incEn[g+2] = eventVec[sel_q[g]] & ~inhibit_q[g+3];
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      writeHalf[i] = HALF_NONE;
      if (csrWriteEnable) begin
        if (csrWriteAddress == CSR_MCYCLE + 12'(slotToCsr(i))) begin
          writeHalf[i] = HALF_LO;
        end else if (csrWriteAddress == CSR_MCYCLEH + 12'(slotToCsr(i))) begin
          writeHalf[i] = HALF_HI;
        end
      end
    end
  end

  always_comb begin
    inhibit_d = inhibit_q;
    sel_d     = sel_q;
    if (csrWriteEnable) begin
      if (csrWriteAddress == CSR_MCOUNTINHIBIT) begin
        inhibit_d = csrWriteData & INHIBIT_MASK;
      end
      for (int unsigned k = 0; k < NUM_HPM; k++) begin
        if (csrWriteAddress == CSR_MHPMEVENT3 + 12'(k)) begin
          sel_d[k] = (csrWriteData > 32'(NUM_EVENTS)) ? '0
                                                      : csrWriteData[EVENT_SEL_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inhibit_q <= '0;
      for (int unsigned k = 0; k < SEL_SLOTS; k++) begin
        sel_q[k] <= '0;
      end
    end else begin
      inhibit_q <= inhibit_d;
      sel_q     <= sel_d;
    end
  end

`ifdef PERF_COUNTER_OVF_EN
  logic [31:0] ovf_q, ovf_d;
  logic [31:0] wrapBits, ovfClear;
  logic        perfIrq_q;

  // Set is ORed in after the clear so a same-cycle wrap survives a clear.
  always_comb begin
    wrapBits = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      wrapBits[5'(slotToCsr(i))] = wrap[i];
    end
    ovfClear = (csrWriteEnable && csrWriteAddress == CSR_MHPMOVF) ? csrWriteData : '0;
    ovf_d    = (ovf_q & ~ovfClear) | wrapBits;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ovf_q     <= '0;
      perfIrq_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      perfIrq_q <= |ovf_d;
    end
  end

  assign perfIrq = perfIrq_q;
`else
  logic unusedWrap;
  assign unusedWrap = |wrap;
`endif

  always_comb begin
    csrReadHit  = 1'b0;
    csrReadData = '0;
    for (int unsigned i = 0; i < NUM_CNT; i++) begin
      if (csrReadAddress == CSR_MCYCLE + 12'(slotToCsr(i))) begin
        csrReadHit  = 1'b1;
        csrReadData = countExt[i][31:0];
      end
      if (csrReadAddress == CSR_MCYCLEH + 12'(slotToCsr(i))) begin
        csrReadHit  = 1'b1;
        csrReadData = countExt[i][63:32];
      end
    end
    if (csrReadAddress == CSR_MCOUNTINHIBIT) begin
      csrReadHit  = 1'b1;
      csrReadData = inhibit_q;
    end
    for (int unsigned k = 0; k < NUM_HPM; k++) begin
      if (csrReadAddress == CSR_MHPMEVENT3 + 12'(k)) begin
        csrReadHit  = 1'b1;
        csrReadData = 32'(sel_q[k]);
      end
    end
`ifdef PERF_COUNTER_OVF_EN
    if (csrReadAddress == CSR_MHPMOVF) begin
      csrReadHit  = 1'b1;
      csrReadData = ovf_q;
    end
`endif
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank with a CSR-level behavioural model
// compared every cycle, plus hand-computed literal read checks.
module tb_perf_counter_bank;

  localparam int unsigned NUM_HPM    = 4;
  localparam int unsigned NUM_EVENTS = 8;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic                  instretEvent;
  logic [NUM_EVENTS-1:0] hpmEvents;
  logic [11:0]           csrReadAddress;
  logic [31:0]           csrReadData;
  logic                  csrReadHit;
  logic                  csrWriteEnable;
  logic [11:0]           csrWriteAddress;
  logic [31:0]           csrWriteData;
`ifdef PERF_COUNTER_OVF_EN
  logic                  perfIrq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(
    .NUM_HPM       (NUM_HPM),
    .COUNTER_WIDTH (64),
    .NUM_EVENTS    (NUM_EVENTS)
  ) dut (
    .clk             (clk),
    .resetN          (resetN),
    .instretEvent    (instretEvent),
    .hpmEvents       (hpmEvents),
    .csrReadAddress  (csrReadAddress),
    .csrReadData     (csrReadData),
    .csrReadHit      (csrReadHit),
    .csrWriteEnable  (csrWriteEnable),
    .csrWriteAddress (csrWriteAddress),
    .csrWriteData    (csrWriteData)
`ifdef PERF_COUNTER_OVF_EN
    ,
    .perfIrq         (perfIrq)
`endif
  );

  // ---------------- behavioural model, indexed by CSR counter number ----------------
  longint unsigned mCnt [32];
  int unsigned     mSel [32];
  logic [31:0]     mInh;
  logic [31:0]     mOvf;

  function automatic bit impl(input int unsigned n);
    return (n == 0) || (n == 2) || (n >= 3 && n < 3 + NUM_HPM);
  endfunction

  function automatic logic [31:0] implMask();
    logic [31:0] m;
    m = '0;
    for (int unsigned n = 0; n < 32; n++) begin
      if (impl(n) && n != 1) m[5'(n)] = 1'b1;
    end
    return m;
  endfunction

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int unsigned n = 0; n < 32; n++) begin
        mCnt[n] <= 0;
        mSel[n] <= 0;
      end
      mInh <= '0;
      mOvf <= '0;
    end else begin : model_step
      longint unsigned v;
      bit              inc;
      logic [31:0]     wrapv;
      int unsigned     a;
      a     = 32'(csrWriteAddress);
      wrapv = '0;
      for (int unsigned n = 0; n < 32; n++) begin
        if (impl(n)) begin
          if (n == 0)      inc = 1'b1;
          else if (n == 2) inc = instretEvent;
          else             inc = (mSel[n] != 0) && hpmEvents[3'(mSel[n] - 1)];
          inc = inc && !mInh[5'(n)];
          v = mCnt[n];
          if (csrWriteEnable && a == 32'hB00 + n) begin
            v = {v[63:32], csrWriteData};
          end else if (csrWriteEnable && a == 32'hB80 + n) begin
            v = {csrWriteData, v[31:0]};
          end else if (inc) begin
            v = v + 1;
            if (v == 0) wrapv[5'(n)] = 1'b1;
          end
          mCnt[n] <= v;
        end
      end
      if (csrWriteEnable && a == 32'h320) mInh <= csrWriteData & implMask();
      if (csrWriteEnable && a >= 32'h323 && a <= 32'h320 + NUM_HPM + 2) begin
        mSel[5'(a - 32'h320)] <= (csrWriteData > NUM_EVENTS) ? 0 : csrWriteData;
      end
      if (csrWriteEnable && a == 32'h7C0) mOvf <= (mOvf & ~csrWriteData) | wrapv;
      else                                mOvf <= mOvf | wrapv;
    end
  end

  function automatic logic [32:0] model_read(input logic [11:0] addr);
    int unsigned a;
    a = 32'(addr);
    if (a >= 32'hB00 && a <= 32'hB1F && impl(a - 32'hB00))
      return {1'b1, mCnt[5'(a - 32'hB00)][31:0]};
    if (a >= 32'hB80 && a <= 32'hB9F && impl(a - 32'hB80))
      return {1'b1, mCnt[5'(a - 32'hB80)][63:32]};
    if (a == 32'h320)
      return {1'b1, mInh};
    if (a >= 32'h323 && a <= 32'h320 + NUM_HPM + 2)
      return {1'b1, mSel[5'(a - 32'h320)]};
`ifdef PERF_COUNTER_OVF_EN
    if (a == 32'h7C0)
      return {1'b1, mOvf};
`endif
    return '0;
  endfunction

  // ---------------- checking and stimulus helpers ----------------
  task automatic cycle_compare();
    logic [32:0] e;
    e = model_read(csrReadAddress);
    checks++;
    if ({csrReadHit, csrReadData} !== e) begin
      errors++;
      $display("FAIL cycle_read @%0t addr=0x%03h: got hit=%0b data=0x%08h, want hit=%0b data=0x%08h",
               $time, csrReadAddress, csrReadHit, csrReadData, e[32], e[31:0]);
    end
`ifdef PERF_COUNTER_OVF_EN
    checks++;
    if (perfIrq !== (mOvf != 0)) begin
      errors++;
      $display("FAIL cycle_irq @%0t: got perfIrq=%0b, want %0b", $time, perfIrq, (mOvf != 0));
    end
`endif
  endtask

  // Every clock passes through here, so the model is compared on each falling edge.
  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(negedge clk);
      cycle_compare();
      @(posedge clk);
    end
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csrWriteEnable  = 1'b1;
    csrWriteAddress = a;
    csrWriteData    = d;
    tick();
    csrWriteEnable  = 1'b0;
  endtask

  task automatic chk(input string name, input logic [11:0] a, input logic expHit,
                     input logic [31:0] expData);
    csrReadAddress = a;
    #1;
    checks++;
    if (csrReadHit !== expHit || csrReadData !== expData) begin
      errors++;
      $display("FAIL %s addr=0x%03h: got hit=%0b data=0x%08h, want hit=%0b data=0x%08h",
               name, a, csrReadHit, csrReadData, expHit, expData);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetN          = 1'b0;
    instretEvent    = 1'b0;
    hpmEvents       = '0;
    csrReadAddress  = 12'hB00;
    csrWriteEnable  = 1'b0;
    csrWriteAddress = '0;
    csrWriteData    = '0;

    tick(2);
    chk("reset_mcycle", 12'hB00, 1'b1, 32'd0);
    chk("reset_mhpm3h", 12'hB83, 1'b1, 32'd0);
    resetN = 1'b1;

    tick(10);
    chk("idle_mcycle",   12'hB00, 1'b1, 32'd10);
    chk("idle_minstret", 12'hB02, 1'b1, 32'd0);
    chk("idle_mhpm3",    12'hB03, 1'b1, 32'd0);

    csr_write(12'h323, 32'd2);
    for (int unsigned i = 0; i < 5; i++) begin
      hpmEvents = 8'h02;
      tick();
      hpmEvents = 8'h01;
      tick();
    end
    hpmEvents = '0;
    chk("sel2_count",  12'hB03, 1'b1, 32'd5);
    chk("sel2_readbk", 12'h323, 1'b1, 32'd2);

    csr_write(12'h323, 32'd200);
    chk("sel200_zero", 12'h323, 1'b1, 32'd0);
    hpmEvents = 8'hFF;
    tick(3);
    hpmEvents = '0;
    chk("sel0_frozen", 12'hB03, 1'b1, 32'd5);

    csr_write(12'h323, 32'd8);
    hpmEvents = 8'h80;
    tick();
    hpmEvents = '0;
    chk("sel8_count", 12'hB03, 1'b1, 32'd6);
    csr_write(12'h323, 32'd9);
    chk("sel9_zero", 12'h323, 1'b1, 32'd0);

    csr_write(12'hB80, 32'hFFFF_FFFF);
    csr_write(12'hB00, 32'hFFFF_FFFF);
    chk("wr_mcycle",  12'hB00, 1'b1, 32'hFFFF_FFFF);
    chk("wr_mcycleh", 12'hB80, 1'b1, 32'hFFFF_FFFF);
    tick();
    chk("wrap_lo", 12'hB00, 1'b1, 32'd0);
    chk("wrap_hi", 12'hB80, 1'b1, 32'd0);
    tick();
    chk("post_wrap_lo", 12'hB00, 1'b1, 32'd1);
    chk("post_wrap_hi", 12'hB80, 1'b1, 32'd0);

    instretEvent = 1'b1;
    csr_write(12'h320, 32'h4);
    tick(5);
    chk("inh_minstret", 12'hB02, 1'b1, 32'd1);
    chk("inh_readbk",   12'h320, 1'b1, 32'h4);
    csr_write(12'h320, 32'hFFFF_FFFF);
    chk("inh_mask",       12'h320, 1'b1, 32'h7D);
    chk("inh_all_mcycle", 12'hB00, 1'b1, 32'd8);
    tick(2);
    chk("inh_all_frozen", 12'hB00, 1'b1, 32'd8);
    chk("inh_all_instr",  12'hB02, 1'b1, 32'd1);
    csr_write(12'h320, 32'h0);
    chk("inh_clear_edge", 12'hB00, 1'b1, 32'd8);

    csr_write(12'hB02, 32'd100);
    chk("wr_minstret",   12'hB02, 1'b1, 32'd100);
    chk("mcycle_resume", 12'hB00, 1'b1, 32'd9);
    tick();
    chk("minstret_next", 12'hB02, 1'b1, 32'd101);

`ifdef PERF_COUNTER_OVF_EN
    chk("ovf_set", 12'h7C0, 1'b1, 32'h1);
    csr_write(12'h7C0, 32'h1);
    chk("ovf_clear", 12'h7C0, 1'b1, 32'h0);
`endif

    tick(3);
    resetN          = 1'b0;
    csrWriteEnable  = 1'b1;
    csrWriteAddress = 12'hB03;
    csrWriteData    = 32'd55;
    chk("rst_mcycle",   12'hB00, 1'b1, 32'd0);
    chk("rst_minstret", 12'hB02, 1'b1, 32'd0);
    tick();
    csrWriteEnable = 1'b0;
    chk("rst_write_lost", 12'hB03, 1'b1, 32'd0);
    resetN       = 1'b1;
    instretEvent = 1'b0;
    tick(3);
    chk("post_rst_mcycle",   12'hB00, 1'b1, 32'd3);
    chk("post_rst_minstret", 12'hB02, 1'b1, 32'd0);
    chk("miss_b1f",          12'hB1F, 1'b0, 32'd0);

    csr_write(12'hB1F, 32'd1234);
    chk("miss_b1f_wr", 12'hB1F, 1'b0, 32'd0);
    chk("miss_321",    12'h321, 1'b0, 32'd0);
    chk("miss_b07",    12'hB07, 1'b0, 32'd0);
    csr_write(12'h321, 32'd5);
    chk("miss_321_wr", 12'h321, 1'b0, 32'd0);
`ifdef PERF_COUNTER_OVF_EN
    chk("ovf_present", 12'h7C0, 1'b1, 32'd0);
`else
    chk("miss_7c0",    12'h7C0, 1'b0, 32'd0);
`endif
    chk("miss_b01",    12'hB01, 1'b0, 32'd0);
    tick();
    chk("miss_b81",    12'hB81, 1'b0, 32'd0);
    chk("miss_b87",    12'hB87, 1'b0, 32'd0);
    chk("last_event",  12'h326, 1'b1, 32'd0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
